// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM burst reader.
// Default widths match the truedual wrapper ports.
package bram_rd_pkg;

   localparam int unsigned DefAw = 10;
   localparam int unsigned DefDw = 16;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StFinish
   } rd_state_e;

   // Width needed to index 'value' entries; never returns less than 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned result;
      v = (value > 1) ? value - 1 : 0;
      result = 0;
      while (v > 0) begin
         v = v >> 1;
         result++;
      end
      return (result == 0) ? 1 : result;
   endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, data} beats.
// Depth must be a power of two so the pointers wrap naturally.
module bram_rd_fifo
   import bram_rd_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             empty
);

   localparam int unsigned PW = clog2(Depth);
   localparam int unsigned CW = clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read master for one BRAM port: issues one read per cycle under a credit limit,
// absorbs the read latency and presents the words as a valid/ready stream with last marker.
module bram_burst_reader
   import bram_rd_pkg::*;
#(
   parameter int unsigned AW        = DefAw,
   parameter int unsigned DW        = DefDw,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   length,
   output logic          busy,
   output logic          done,
   output logic          mem_rden,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_dout,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   input  logic          m_ready
);

   localparam int unsigned CRW = clog2(BUF_DEPTH + 1);

   rd_state_e         state_q, state_d;
   logic [AW:0]       len_q;
   logic [AW:0]       remaining_q, remaining_d;
   logic [AW:0]       wr_cnt_q, wr_cnt_d;
   logic [CRW-1:0]    credit_q, credit_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              rden_q, rden_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [RD_LAT-1:0] rd_pipe_q;

   logic              push, pop, push_last;
   logic              fifo_empty, fifo_last;
   logic [DW-1:0]     fifo_data;
   logic [DW:0]       fifo_wdata, fifo_rdata;

   assign push       = rd_pipe_q[RD_LAT-1];
   assign pop        = m_valid && m_ready;
   assign push_last  = ((wr_cnt_q + (AW+1)'(1)) == len_q);
   assign fifo_wdata = {push_last, mem_dout};
   assign fifo_last  = fifo_rdata[DW];
   assign fifo_data  = fifo_rdata[DW-1:0];

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q - (AW+1)'(rden_q);
      addr_d      = addr_q + AW'(rden_q);
      wr_cnt_d    = wr_cnt_q + (AW+1)'(push);
      credit_d    = credit_q + CRW'(rden_q) - CRW'(pop);
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = length;
               addr_d      = start_addr;
               wr_cnt_d    = '0;
               busy_d      = 1'b1;
               state_d     = (length == '0) ? StFinish : StIssue;
            end
         end
         StIssue: begin
            if (remaining_d == '0) state_d = StDrain;
         end
         StDrain: begin
            if (pop && m_last) begin
               state_d = StFinish;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         StFinish: begin
            // Zero-length commands arrive here still busy and pulse done one cycle later.
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      rden_d = (state_d == StIssue) && (credit_d < CRW'(BUF_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         len_q       <= '0;
         remaining_q <= '0;
         wr_cnt_q    <= '0;
         credit_q    <= '0;
         addr_q      <= '0;
         rden_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_pipe_q   <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wr_cnt_q    <= wr_cnt_d;
         credit_q    <= credit_d;
         addr_q      <= addr_d;
         rden_q      <= rden_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         if (state_q == StIdle && start) len_q <= length;
         rd_pipe_q[0] <= rden_q;
         for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
   end

   bram_rd_fifo #(
      .Depth (BUF_DEPTH),
      .Width (DW + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_rden = rden_q;
   assign mem_addr = addr_q;
   assign m_valid  = !fifo_empty;
   assign m_data   = m_valid ? fifo_data : '0;
   assign m_last   = m_valid && fifo_last;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader with a one-cycle-latency BRAM model on its read port;
// the model array is preloaded directly in place of a port-A writer.
module tb_bram_burst_reader;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, mem_rden, m_valid, m_last;
   logic          m_ready = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout = '0;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   bram_burst_reader #(
      .AW        (AW),
      .DW        (DW),
      .RD_LAT    (1),
      .BUF_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .mem_rden   (mem_rden),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_ready    (m_ready)
   );

   logic [DW-1:0] bram [1024];
   always @(posedge clk) if (mem_rden) mem_dout <= bram[mem_addr];

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int total = 0;
   int bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor state, sampled on the falling edge.
   logic [DW-1:0] beats[$];
   logic          lasts[$];
   logic [AW-1:0] rd_addrs[$];
   int            valid_cnt, busy_cnt, done_cnt, credit_viol, stall_viol, mdl_credit;
   int            first_rden, first_valid, last_edge, done_edge, start_cyc;
   logic          prev_stall, prev_last;
   logic [DW-1:0] prev_data;

   task automatic clear_mon();
      beats.delete();
      lasts.delete();
      rd_addrs.delete();
      valid_cnt = 0; busy_cnt = 0; done_cnt = 0; credit_viol = 0; stall_viol = 0;
      first_rden = -1; first_valid = -1; last_edge = -1; done_edge = -1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mdl_credit = 0;
         prev_stall = 1'b0;
      end else begin
         if (mem_rden) begin
            if (mdl_credit >= 4) credit_viol++;
            rd_addrs.push_back(mem_addr);
            if (first_rden < 0) first_rden = edge_cnt;
         end
         if (m_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = edge_cnt;
         end
         if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
            stall_viol++;
         if (m_valid && m_ready) begin
            beats.push_back(m_data);
            lasts.push_back(m_last);
            if (m_last) last_edge = edge_cnt;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_edge = edge_cnt;
         end
         mdl_credit = mdl_credit + int'(mem_rden) - int'(m_valid && m_ready);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   function automatic logic [31:0] beat_at(input int i);
      return (i < beats.size()) ? 32'(beats[i]) : 32'hffff_ffff;
   endfunction

   function automatic logic [31:0] last_mask();
      logic [31:0] m = '0;
      for (int i = 0; i < lasts.size() && i < 32; i++) m[i] = lasts[i];
      return m;
   endfunction

   task automatic preload();
      for (int k = 0; k < 1024; k++) bram[k] = '0;
      for (int k = 0; k < 16; k++) bram[k] = 16'h1000 + 16'(k);
   endtask

   logic [3:0] rdy_pat = 4'b1001;

   // Entered and left at #1 after a rising edge.
   task automatic run_burst(input logic [AW-1:0] a, input logic [AW:0] l, input bit stall,
                            input int restart_at, input string tag);
      bit ok;
      ok = 1'b0;
      start = 1'b1; start_addr = a; length = l; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = edge_cnt - 1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
         @(posedge clk); #1;
         start = (i == restart_at);
         if (start) begin
            start_addr = 10'd10;
            length     = 11'd3;
         end
         m_ready = stall ? rdy_pat[i % 4] : 1'b1;
      end
      check_val({tag, "_done_seen"}, 32'(ok), 32'd1);
      start = 1'b0;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      preload();
      clear_mon();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_rden", 32'(mem_rden), 32'd0);
      check_val("rst_addr", 32'(mem_addr), 32'd0);
      check_val("rst_valid", 32'(m_valid), 32'd0);
      check_val("rst_data", 32'(m_data), 32'd0);
      @(posedge clk); #1;

      // 1: basic 4-word burst
      clear_mon();
      run_burst(10'd2, 11'd4, 1'b0, -1, "t1");
      check_val("t1_count", beats.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("t1_beat%0d", i), beat_at(i), 32'h1002 + 32'(i));
      check_val("t1_lastmask", last_mask(), 32'h8);
      check_val("t1_rden_lat", 32'(first_rden - start_cyc), 32'd1);
      check_val("t1_valid_lat", 32'(first_valid - start_cyc), 32'd3);
      check_val("t1_done_after_last", 32'(done_edge - last_edge), 32'd1);
      check_val("t1_done_cnt", 32'(done_cnt), 32'd1);

      // 2: 8 words with m_ready pattern 1,0,0,1
      clear_mon();
      run_burst(10'd0, 11'd8, 1'b1, -1, "t2");
      check_val("t2_count", beats.size(), 32'd8);
      for (int i = 0; i < 8; i++)
         check_val($sformatf("t2_beat%0d", i), beat_at(i), 32'h1000 + 32'(i));
      check_val("t2_lastmask", last_mask(), 32'h80);
      check_val("t2_reads", rd_addrs.size(), 32'd8);
      check_val("t2_credit_viol", 32'(credit_viol), 32'd0);
      check_val("t2_stall_viol", 32'(stall_viol), 32'd0);

      // 3: address wrap
      bram[1022] = 16'hAAAA; bram[1023] = 16'hBBBB; bram[0] = 16'hCCCC;
      clear_mon();
      run_burst(10'd1022, 11'd3, 1'b0, -1, "t3");
      check_val("t3_reads", rd_addrs.size(), 32'd3);
      check_val("t3_addr0", (rd_addrs.size() > 0) ? 32'(rd_addrs[0]) : 32'hffff, 32'd1022);
      check_val("t3_addr1", (rd_addrs.size() > 1) ? 32'(rd_addrs[1]) : 32'hffff, 32'd1023);
      check_val("t3_addr2", (rd_addrs.size() > 2) ? 32'(rd_addrs[2]) : 32'hffff, 32'd0);
      check_val("t3_beat0", beat_at(0), 32'hAAAA);
      check_val("t3_beat1", beat_at(1), 32'hBBBB);
      check_val("t3_beat2", beat_at(2), 32'hCCCC);
      preload();

      // 4: zero length
      clear_mon();
      run_burst(10'd5, 11'd0, 1'b0, -1, "t4");
      check_val("t4_reads", rd_addrs.size(), 32'd0);
      check_val("t4_valid_cycles", 32'(valid_cnt), 32'd0);
      check_val("t4_busy_cycles", 32'(busy_cnt), 32'd1);
      check_val("t4_done_cnt", 32'(done_cnt), 32'd1);

      // 5: second start while busy is ignored
      clear_mon();
      run_burst(10'd4, 11'd4, 1'b0, 1, "t5");
      repeat (10) @(posedge clk);
      #1;
      check_val("t5_count", beats.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("t5_beat%0d", i), beat_at(i), 32'h1004 + 32'(i));
      check_val("t5_done_cnt", 32'(done_cnt), 32'd1);

      // 6: reset mid-burst, then a fresh burst
      clear_mon();
      start = 1'b1; start_addr = '0; length = 11'd16; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && n < 5; i++) begin
         @(negedge clk);
         if (m_valid && m_ready) n++;
      end
      check_val("t6_beats_before_rst", 32'(n), 32'd5);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_val("t6_busy", 32'(busy), 32'd0);
      check_val("t6_done", 32'(done), 32'd0);
      check_val("t6_rden", 32'(mem_rden), 32'd0);
      check_val("t6_addr", 32'(mem_addr), 32'd0);
      check_val("t6_valid", 32'(m_valid), 32'd0);
      check_val("t6_data", 32'(m_data), 32'd0);
      check_val("t6_last", 32'(m_last), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check_val("t6_no_done", 32'(done_cnt), 32'd0);
      clear_mon();
      run_burst(10'd0, 11'd2, 1'b0, -1, "t6b");
      check_val("t6b_count", beats.size(), 32'd2);
      check_val("t6b_beat0", beat_at(0), 32'h1000);
      check_val("t6b_beat1", beat_at(1), 32'h1001);
      check_val("t6b_lastmask", last_mask(), 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
